// File: rtl/pix_stream_pkg.sv
// rtl/pix_stream_pkg.sv - shared types and default sizes for the row streamer
package pix_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH  = 120;
    localparam int DEFAULT_HEIGHT = 52;
    localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/pix_row_select.sv
// rtl/pix_row_select.sv - combinational row mux from a row-major frame buffer
module pix_row_select
    import pix_stream_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic [WIDTH*HEIGHT-1:0] frame_buf_i,
    input  logic [ROW_W-1:0]        row_idx_i,
    output logic [WIDTH-1:0]        row_data_o
);

    // Explicit compare per row keeps out-of-range indices returning zero.
    always_comb begin
        row_data_o = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (row_idx_i == ROW_W'(r)) begin
                row_data_o = frame_buf_i[r*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pix_row_streamer.sv
// rtl/pix_row_streamer.sv - captures a full frame and streams it out one row per beat
module pix_row_streamer
    import pix_stream_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int CNT_W  = DEFAULT_CNT_W,
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [WIDTH*HEIGHT-1:0] pix_in,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    output logic [WIDTH-1:0]        row_data,
    output logic [ROW_W-1:0]        row_idx,
    output logic                    row_last,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [CNT_W-1:0]        frame_count,
    output logic                    busy
);

    localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(HEIGHT - 1);

    state_e                  state_q;
    logic [WIDTH*HEIGHT-1:0] frame_q;
    logic [ROW_W-1:0]        row_idx_q;
    logic                    row_last_q;
    logic [CNT_W-1:0]        frame_count_q;

    logic beat;
    logic accept;

    assign beat   = (state_q == STREAM) && row_ready;
    // The last beat doubles as an acceptance slot so frames can run back-to-back.
    assign frame_ready = rst_n && !flush &&
                         ((state_q == IDLE) || (beat && row_last_q));
    assign accept = frame_valid && frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            row_idx_q     <= '0;
            row_last_q    <= 1'b0;
            frame_count_q <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            row_idx_q  <= '0;
            row_last_q <= 1'b0;
        end else begin
            if (beat) begin
                if (row_last_q) begin
                    frame_count_q <= frame_count_q + CNT_W'(1);
                    row_idx_q     <= '0;
                    row_last_q    <= 1'b0;
                    state_q       <= IDLE;
                end else begin
                    row_idx_q  <= row_idx_q + ROW_W'(1);
                    row_last_q <= ((row_idx_q + ROW_W'(1)) == LAST_IDX);
                end
            end
            if (accept) begin
                frame_q    <= pix_in;
                state_q    <= STREAM;
                row_idx_q  <= '0;
                row_last_q <= (HEIGHT == 1);
            end
        end
    end

    pix_row_select #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ROW_W  (ROW_W)
    ) u_row_select (
        .frame_buf_i (frame_q),
        .row_idx_i   (row_idx_q),
        .row_data_o  (row_data)
    );

    assign row_idx     = row_idx_q;
    assign row_last    = row_last_q;
    assign row_valid   = (state_q == STREAM);
    assign busy        = (state_q == STREAM);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pix_row_streamer.sv
// tb/tb_pix_row_streamer.sv - randomized self-checking bench against a row-queue model
module tb_pix_row_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 4;
    localparam int RW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [W*H-1:0]  pix_in = '0;
    logic            frame_valid = 1'b0;
    logic            row_ready = 1'b0;
    logic            frame_ready;
    logic [W-1:0]    row_data;
    logic [RW-1:0]   row_idx;
    logic            row_last;
    logic            row_valid;
    logic [CW-1:0]   frame_count;
    logic            busy;

    always #5 clk = ~clk;

    pix_row_streamer #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .pix_in      (pix_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .row_last    (row_last),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .frame_count (frame_count),
        .busy        (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        int           idx;
    } row_t;

    row_t exp_q[$];
    int   exp_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   last_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // A frame may enter when nothing is held, or when the final row leaves this cycle.
    function automatic bit model_ready();
        return !flush && (exp_q.size() == 0 || (row_ready && exp_q[0].idx == H - 1));
    endfunction

    task automatic compare();
        bit v;
        v = (exp_q.size() > 0);
        check("row_valid", 32'(row_valid), 32'(v));
        check("busy", 32'(busy), 32'(v));
        check("frame_ready", 32'(frame_ready), 32'(model_ready()));
        check("frame_count", 32'(frame_count), 32'(exp_cnt));
        check("row_idx", 32'(row_idx), v ? 32'(exp_q[0].idx) : 32'd0);
        check("row_last", 32'(row_last), v ? 32'(exp_q[0].idx == H - 1) : 32'd0);
        if (v) check("row_data", 32'(row_data), 32'(exp_q[0].data));
    endtask

    task automatic model_update();
        bit rdy;
        bit last;
        rdy = model_ready();
        last_acc = 0;
        if (exp_q.size() > 0 && row_ready) begin
            last = (exp_q[0].idx == H - 1);
            void'(exp_q.pop_front());
            if (last && !flush) exp_cnt = (exp_cnt + 1) % (1 << CW);
        end
        if (flush) exp_q.delete();
        if (frame_valid && rdy) begin
            last_acc = 1;
            for (int r = 0; r < H; r++)
                exp_q.push_back('{data: W'(pix_in >> (r * W)), idx: r});
        end
    endtask

    task automatic step(input logic fv, input logic [W*H-1:0] px, input logic rr, input logic fl);
        @(negedge clk);
        frame_valid = fv;
        pix_in      = px;
        row_ready   = rr;
        flush       = fl;
        #1 compare();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        logic            pend_fv;
        logic [W*H-1:0]  pend_px;
        logic            rr_pat [5];

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_frame_ready", 32'(frame_ready), 32'd0);
        check("reset_row_valid", 32'(row_valid), 32'd0);
        check("reset_row_data", 32'(row_data), 32'd0);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;

        // single frame: rows C, 5, A
        step(1, 12'hA5C, 1, 0);
        for (int i = 0; i < H; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        check("count_after_first", 32'(frame_count), 32'd1);

        // backpressure with next frame pending
        step(1, 12'h3C6, 1, 0);
        rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) step(1, 12'h777, rr_pat[i], 0);
        for (int i = 0; i < H; i++) step(0, '0, 1, 0);

        // back-to-back A then B
        step(1, 12'hA5C, 1, 0);
        for (int i = 0; i < H; i++) step(1, 12'h123, 1, 0);
        for (int i = 0; i < H + 1; i++) step(0, '0, 1, 0);

        // flush after row 1 beat, frame offered in the flush cycle
        step(1, 12'hBEE, 1, 0);
        step(0, '0, 1, 0);
        step(1, 12'h456, 0, 1);
        step(0, '0, 0, 0);

        // async reset mid-stream while row 1 is presented
        step(1, 12'h9E1, 1, 0);
        step(0, '0, 1, 0);
        @(negedge clk);
        row_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_row_valid", 32'(row_valid), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_frame_ready", 32'(frame_ready), 32'd0);
        check("areset_count", 32'(frame_count), 32'd0);
        check("areset_row_idx", 32'(row_idx), 32'd0);
        check("areset_row_data", 32'(row_data), 32'd0);
        check("areset_row_last", 32'(row_last), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 12'h9E1, 1, 0);
        for (int i = 0; i < H; i++) step(0, '0, 1, 0);

        // 16 back-to-back frames wrap the 4-bit counter back to 1
        for (int i = 0; i <= 16 * H; i++) step(i < 16 * H, 12'($urandom), 1, 0);
        step(0, '0, 1, 0);
        check("count_wrap", 32'(frame_count), 32'd1);

        // flush on the last beat must not count
        step(1, 12'h5A5, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 1);
        step(0, '0, 1, 0);
        check("count_flush_last", 32'(frame_count), 32'd1);

        // randomized traffic; upstream holds a frame until accepted
        pend_fv = 1'b0;
        pend_px = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_fv && $urandom_range(0, 2) == 0) begin
                pend_fv = 1'b1;
                pend_px = 12'($urandom);
            end
            step(pend_fv, pend_px, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            if (last_acc) pend_fv = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
